// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared encodings for the reflet two-master bus arbiter.
// Only plain localparams live here so the arbiter stays a single flat module.
package reflet_bus_arbiter_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Read-data owner encoding (who issued the access one cycle ago)
  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_M0   = 2'd1;
  localparam logic [1:0] RD_M1   = 2'd2;

endpackage

// File: rtl/reflet_bus_arbiter.sv
// Two-master bus arbiter: CPU (master 0) and DMA/debug (master 1) share one
// bus. Ownership is registered and bounded by max_burst when both masters
// compete, and every hand-over passes through one IDLE cycle. Read data is
// routed back one cycle later to whoever owned the bus on the access cycle.
module reflet_bus_arbiter
  import reflet_bus_arbiter_pkg::*;
#(
  parameter int wordsize  = 16,
  parameter int max_burst = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m0_data_out,
  input  logic [wordsize-1:0] m1_data_out,
  input  logic                m0_write_en,
  input  logic                m1_write_en,
  output logic                m0_grant,
  output logic                m1_grant,
  output logic [wordsize-1:0] m0_data_in,
  output logic [wordsize-1:0] m1_data_in,
  output logic [wordsize-1:0] bus_addr,
  output logic [wordsize-1:0] bus_data_out,
  output logic                bus_write_en,
  input  logic [wordsize-1:0] bus_data_in,
  output logic                busy
);

  localparam int CNT_W = (max_burst > 1) ? $clog2(max_burst) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_burst - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last_owner;
  logic             last_owner_next;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_next;
  logic [1:0]       rd_owner;

  // State, fairness history, burst counter and read-owner registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      rd_owner   <= RD_NONE;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      burst_cnt  <= burst_cnt_next;
      case (state)
        ST_OWN0: rd_owner <= RD_M0;
        ST_OWN1: rd_owner <= RD_M1;
        default: rd_owner <= RD_NONE;
      endcase
    end
  end

  // Next-state arbitration: tie-break on last owner, forced release at burst limit
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    burst_cnt_next  = '0;
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req)
          state_next = last_owner ? ST_OWN0 : ST_OWN1;
        else if (m0_req)
          state_next = ST_OWN0;
        else if (m1_req)
          state_next = ST_OWN1;
        else
          state_next = ST_IDLE;
      end
      ST_OWN0: begin
        if (!m0_req || (m1_req && (burst_cnt == CNT_MAX))) begin
          state_next      = ST_IDLE;
          last_owner_next = 1'b0;
        end else begin
          burst_cnt_next = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
        end
      end
      ST_OWN1: begin
        if (!m1_req || (m0_req && (burst_cnt == CNT_MAX))) begin
          state_next      = ST_IDLE;
          last_owner_next = 1'b1;
        end else begin
          burst_cnt_next = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign m0_grant = (state == ST_OWN0);
  assign m1_grant = (state == ST_OWN1);
  assign busy     = m0_grant | m1_grant;

  // Shared bus mux: only the granted master reaches the bus, zeros when idle
  always_comb begin
    bus_addr     = '0;
    bus_data_out = '0;
    bus_write_en = 1'b0;
    if (m0_grant) begin
      bus_addr     = m0_addr;
      bus_data_out = m0_data_out;
      bus_write_en = m0_write_en;
    end else if (m1_grant) begin
      bus_addr     = m1_addr;
      bus_data_out = m1_data_out;
      bus_write_en = m1_write_en;
    end
  end

  assign m0_data_in = (rd_owner == RD_M0) ? bus_data_in : '0;
  assign m1_data_in = (rd_owner == RD_M1) ? bus_data_in : '0;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Directed bench for reflet_bus_arbiter: default instance (max_burst=16)
// plus a max_burst=1 instance for the strict alternation case.
module tb_reflet_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req;
  logic [15:0] m0_addr, m1_addr, m0_data_out, m1_data_out;
  logic        m0_write_en, m1_write_en;
  logic        m0_grant, m1_grant;
  logic [15:0] m0_data_in, m1_data_in;
  logic [15:0] bus_addr, bus_data_out;
  logic        bus_write_en;
  logic [15:0] bus_data_in;
  logic        busy;

  logic        b_m0_req, b_m1_req;
  logic        b_m0_grant, b_m1_grant;
  logic [15:0] b_m0_data_in, b_m1_data_in;
  logic [15:0] b_bus_addr, b_bus_data_out;
  logic        b_bus_write_en;
  logic        b_busy;

  int vectors;
  int miscompares;

  reflet_bus_arbiter #(.wordsize(16), .max_burst(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
    .m0_write_en(m0_write_en), .m1_write_en(m1_write_en),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
    .bus_addr(bus_addr), .bus_data_out(bus_data_out),
    .bus_write_en(bus_write_en), .bus_data_in(bus_data_in),
    .busy(busy)
  );

  reflet_bus_arbiter #(.wordsize(16), .max_burst(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m1_req(b_m1_req),
    .m0_addr(16'h0A0A), .m1_addr(16'h0B0B),
    .m0_data_out(16'h0000), .m1_data_out(16'h0000),
    .m0_write_en(1'b0), .m1_write_en(1'b0),
    .m0_grant(b_m0_grant), .m1_grant(b_m1_grant),
    .m0_data_in(b_m0_data_in), .m1_data_in(b_m1_data_in),
    .bus_addr(b_bus_addr), .bus_data_out(b_bus_data_out),
    .bus_write_en(b_bus_write_en), .bus_data_in(16'h0000),
    .busy(b_busy)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m1_req = 0;
    m0_addr = 0; m1_addr = 0; m0_data_out = 0; m1_data_out = 0;
    m0_write_en = 0; m1_write_en = 0; bus_data_in = 0;
    b_m0_req = 0; b_m1_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    bus_data_in = 16'hA5A5;
    m0_addr = 16'h1234;
    m0_req = 1;
    #1;
    vectors++;
    if ({m0_grant, m1_grant, busy} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_grants got=%b want=000", {m0_grant, m1_grant, busy});
    end
    tick();
    vectors++;
    if (bus_addr !== 16'h0000 || bus_write_en !== 1'b0 || m0_grant !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus got addr=%h we=%b g0=%b want 0000/0/0", bus_addr, bus_write_en, m0_grant);
    end
    vectors++;
    if (m0_data_in !== 16'h0000 || m1_data_in !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_data_in got=%h/%h want=0000/0000", m0_data_in, m1_data_in);
    end
  endtask

  task automatic test_single_m0();
    do_reset();
    m0_req = 1;
    m0_addr = 16'h1234;
    vectors++;
    if (m0_grant !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_pre_grant got=%b want=0", m0_grant);
    end
    tick();
    vectors++;
    if (m0_grant !== 1'b1 || bus_addr !== 16'h1234 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_first_grant got g0=%b addr=%h busy=%b want 1/1234/1", m0_grant, bus_addr, busy);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      m0_addr = 16'h2000 + 16'(i);
      #1;
      vectors++;
      if (m0_grant !== 1'b1 || m1_grant !== 1'b0 || bus_addr !== 16'h2000 + 16'(i)) begin
        miscompares++;
        $display("[TB] FAIL single_hold[%0d] got g0=%b g1=%b addr=%h want 1/0/%h", i, m0_grant, m1_grant, bus_addr, 16'h2000 + 16'(i));
      end
    end
    m1_req = 1;
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL saturated_release got=%b want=00", {m0_grant, m1_grant});
    end
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL saturated_handover got=%b want=01", {m0_grant, m1_grant});
    end
  endtask

  task automatic test_alternation();
    logic [1:0] want;
    int pos;
    do_reset();
    m0_req = 1;
    m1_req = 1;
    for (int i = 0; i < 70; i++) begin
      tick();
      pos = i % 34;
      want = (pos < 16) ? 2'b10 : ((pos >= 17 && pos < 33) ? 2'b01 : 2'b00);
      vectors++;
      if ({m0_grant, m1_grant} !== want || busy !== (want != 2'b00)) begin
        miscompares++;
        $display("[TB] FAIL alternation[%0d] got g=%b busy=%b want g=%b", i, {m0_grant, m1_grant}, busy, want);
      end
    end
  endtask

  task automatic test_read_data();
    do_reset();
    m1_req = 1;
    tick();
    m1_addr = 16'h8002;
    bus_data_in = 16'h1111;
    #1;
    vectors++;
    if (m1_grant !== 1'b1 || bus_addr !== 16'h8002 || m1_data_in !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL read_issue got g1=%b addr=%h d1=%h want 1/8002/0000", m1_grant, bus_addr, m1_data_in);
    end
    tick();
    bus_data_in = 16'hBEEF;
    #1;
    vectors++;
    if (m1_data_in !== 16'hBEEF || m0_data_in !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL read_return got d1=%h d0=%h want BEEF/0000", m1_data_in, m0_data_in);
    end
    m1_req = 0;
    tick();
    bus_data_in = 16'hCAFE;
    #1;
    vectors++;
    if (m1_grant !== 1'b0 || m1_data_in !== 16'hCAFE) begin
      miscompares++;
      $display("[TB] FAIL read_tail got g1=%b d1=%h want 0/CAFE", m1_grant, m1_data_in);
    end
    tick();
    vectors++;
    if (m1_data_in !== 16'h0000 || m0_data_in !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL read_idle got d1=%h d0=%h want 0000/0000", m1_data_in, m0_data_in);
    end
  endtask

  task automatic test_write_isolation();
    do_reset();
    m0_write_en = 1;
    m1_write_en = 1;
    m1_addr = 16'hFF00;
    #1;
    vectors++;
    if (bus_write_en !== 1'b0 || bus_addr !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL idle_write got we=%b addr=%h want 0/0000", bus_write_en, bus_addr);
    end
    m0_write_en = 0;
    m0_req = 1;
    tick();
    m0_addr = 16'h0040;
    m0_data_out = 16'h5555;
    m1_data_out = 16'hDEAD;
    #1;
    vectors++;
    if (bus_write_en !== 1'b0 || bus_addr !== 16'h0040 || bus_data_out !== 16'h5555) begin
      miscompares++;
      $display("[TB] FAIL m1_write_blocked got we=%b addr=%h data=%h want 0/0040/5555", bus_write_en, bus_addr, bus_data_out);
    end
    m0_write_en = 1;
    #1;
    vectors++;
    if (bus_write_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL m0_write_pass got we=%b want 1", bus_write_en);
    end
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    m1_req = 1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    m1_write_en = 1;
    #1;
    vectors++;
    if (m1_grant !== 1'b1 || bus_write_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_own1 got g1=%b we=%b want 1/1", m1_grant, bus_write_en);
    end
    reset = 0;
    #1;
    vectors++;
    if (m1_grant !== 1'b0 || bus_write_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got g1=%b we=%b busy=%b want 0/0/0", m1_grant, bus_write_en, busy);
    end
    m0_req = 1;
    #2;
    reset = 1;
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL post_reset_first got=%b want=10", {m0_grant, m1_grant});
    end
  endtask

  task automatic test_rerequest();
    do_reset();
    m0_req = 1;
    tick();
    m0_req = 0;
    tick();
    vectors++;
    if (m0_grant !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rereq_drop got=%b want=0", m0_grant);
    end
    m0_req = 1;
    tick();
    vectors++;
    if (m0_grant !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rereq_regrant got=%b want=1", m0_grant);
    end
  endtask

  task automatic test_max_burst_one();
    logic [1:0] want;
    do_reset();
    b_m0_req = 1;
    b_m1_req = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      case (i % 4)
        0:       want = 2'b10;
        2:       want = 2'b01;
        default: want = 2'b00;
      endcase
      vectors++;
      if ({b_m0_grant, b_m1_grant} !== want) begin
        miscompares++;
        $display("[TB] FAIL burst1[%0d] got=%b want=%b", i, {b_m0_grant, b_m1_grant}, want);
      end
    end
  endtask

  // Test sequence
  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 0;
    clear_inputs();
    test_reset();
    test_single_m0();
    test_alternation();
    test_read_data();
    test_write_isolation();
    test_reset_mid_own();
    test_rerequest();
    test_max_burst_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
